// File: rtl/pwm_pkg.sv
// Shared PWM definitions: receiver FSM encoding and the default widths/limits
// that the generator and the receiver agree on.
package pwm_pkg;

    // Counter and measured-word width, same units as the generator's D/period words.
    localparam int unsigned PWM_CNT_W       = 26;

    // Flip-flops in front of the edge register on an asynchronous input.
    localparam int unsigned PWM_SYNC_STAGES = 2;

    // Cycles without a completed period before a measurement is dropped.
    // Also the longest period the generator is allowed to program.
    localparam int unsigned PWM_TIMEOUT     = 1000000;

    // Receiver measurement FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_rx_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_rx_sync_edge.sv
// Synchronizer chain plus one edge register; reports single-cycle rise/fall
// pulses of an asynchronous input. Reusable by any receiver block.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Shift din through the chain; the edge register remembers the last synchronized level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and edge register flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Edge pulses compare the synchronized level with the edge register.
    always_comb begin
        rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_c = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

endmodule : sync_edge

// File: rtl/pwm_rx.sv
// PWM/VPPM receiver: measures high time and rise-to-rise period of a pulse
// train in clk cycles, strobing valid on each completed period and timeout
// when no period completes within TIMEOUT cycles.
module pwm_rx
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = PWM_CNT_W,
    parameter int unsigned SYNC_STAGES = PWM_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = PWM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    pwm_rx_state_e    state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic             rise_c;
    logic             fall_c;
    logic             at_limit_c;

    // Synchronize din and detect its edges.
    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Period counter has run out; pcnt never passes TIMEOUT so it cannot wrap.
    assign at_limit_c = (pcnt_q == TIMEOUT_C);

    // Next-state, counter and strobe logic. A rise in LOW beats the timeout.
    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        pcnt_d       = pcnt_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        valid_d      = 1'b0;
        timeout_d    = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
            pcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // First rise only arms the measurement.
                    if (rise_c) begin
                        state_d = ST_HIGH;
                        hcnt_d  = CNT_ONE;
                        pcnt_d  = CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (at_limit_c) begin
                        state_d   = ST_IDLE;
                        hcnt_d    = '0;
                        pcnt_d    = '0;
                        timeout_d = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + CNT_ONE;
                        if (fall_c) begin
                            state_d = ST_LOW;
                        end else begin
                            hcnt_d = hcnt_q + CNT_ONE;
                        end
                    end
                end
                ST_LOW: begin
                    if (rise_c) begin
                        // Publish and restart with no dead cycle.
                        high_cnt_d   = hcnt_q;
                        period_cnt_d = pcnt_q;
                        valid_d      = 1'b1;
                        state_d      = ST_HIGH;
                        hcnt_d       = CNT_ONE;
                        pcnt_d       = CNT_ONE;
                    end else if (at_limit_c) begin
                        state_d   = ST_IDLE;
                        hcnt_d    = '0;
                        pcnt_d    = '0;
                        timeout_d = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hcnt_d  = '0;
                    pcnt_d  = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hcnt_q       <= '0;
            pcnt_q       <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            pcnt_q       <= pcnt_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;

endmodule : pwm_rx
